alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- single-issue ALU with a one-entry registered output stage.
//
// Purpose
//   Accepts one operation per cycle and returns a registered result, flags and
//   an illegal-opcode flag. Opcodes:
//     0 ADD   1 SUB   2 AND   3 OR   4 XOR   5 SLL   6 SRL   7 SRA
//     8 SLT (signed, 0/1)   9 SLTU (unsigned, 0/1)   10 MUL (optional)
//   Every other opcode is accepted normally and returns
//   result=0, flags=4'b0001, err=1.
//
// Configuration
//   ALU_PIPE_MUL_EN : when defined, opcode 10 runs an iterative shift-add
//                     multiply: one partial product per cycle, with the result
//                     valid on the WIDTH-th edge after accept. When it is
//                     undefined, opcode 10 is illegal and no multiply datapath
//                     exists.
//
// Handshake (valid/ready)
//   Input side : a request transfers on a rising edge where in_valid &&
//                in_ready. in_ready is combinational, and is high only when
//                the block is IDLE and the output register is free or is
//                being drained in the same cycle.
//   Output side: result/flags/err transfer on a rising edge where
//                out_valid && out_ready. They hold stable while
//                out_valid && !out_ready.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   rst        : synchronous active-high reset (takes priority over accept)
//   in_valid   : request present
//   in_ready   : block accepts a request this cycle
//   op[3:0]    : opcode
//   a, b       : operands, WIDTH bits each; the shift amount is b[SHW-1:0]
//   out_valid  : output register holds a result
//   out_ready  : consumer takes the result this cycle
//   result     : registered result
//   flags[3:0] : registered {V,C,N,Z}
//   err        : registered illegal-opcode indicator
//   dbg_busy_o : FSM state for observation (1 = MUL_BUSY)
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  output logic             dbg_busy_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic accept;
  logic drain;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flags      = flags_q;
  assign err        = err_q;
  assign dbg_busy_o = (state_q == MUL_BUSY);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_v_d;
  logic             alu_c_d;
  logic             alu_err_d;
  logic             is_mul_d;
  logic [3:0]       alu_flags_d;

  assign add_w = {1'b0, a} + {1'b0, b};
  // The carry-out of a + ~b + 1 is the "no borrow" bit, i.e. a >= b unsigned.
  assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res_d = '0;
    alu_v_d   = 1'b0;
    alu_c_d   = 1'b0;
    alu_err_d = 1'b0;
    is_mul_d  = 1'b0;
    case (op)
      4'd0: begin
        alu_res_d = add_w[WIDTH-1:0];
        alu_c_d   = add_w[WIDTH];
        alu_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res_d = sub_w[WIDTH-1:0];
        alu_c_d   = sub_w[WIDTH];
        alu_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: alu_res_d = a & b;
      4'd3: alu_res_d = a | b;
      4'd4: alu_res_d = a ^ b;
      4'd5: alu_res_d = a << shamt;
      4'd6: alu_res_d = a >> shamt;
      4'd7: alu_res_d = WIDTH'($signed(a) >>> shamt);
      4'd8: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: alu_res_d = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_PIPE_MUL_EN
      4'd10: is_mul_d = 1'b1;
`endif
      default: alu_err_d = 1'b1;
    endcase
  end

  // An illegal opcode leaves result=0 and V=C=0, so this also yields 4'b0001.
  assign alu_flags_d = {alu_v_d, alu_c_d, alu_res_d[WIDTH-1], ~|alu_res_d};

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------------
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [3:0]       mul_flags;

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_nx;

  // Each busy cycle adds the shifted multiplicand when the current multiplier
  // LSB is set. The last step's sum feeds the output register directly.
  assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done  = (state_q == MUL_BUSY) && (cnt_q == CW'(WIDTH - 1));
  assign mul_res   = acc_nx[WIDTH-1:0];
  assign mul_flags = {1'b0, |acc_nx[2*WIDTH-1:WIDTH], acc_nx[WIDTH-1], ~|acc_nx[WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if ((state_q == IDLE) && accept && is_mul_d) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL_BUSY) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`else
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_flags = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul_d) begin
              // in_ready guarantees that any old result drains on this edge,
              // so the output register is empty for the whole multiply.
              state_q     <= MUL_BUSY;
              out_valid_q <= 1'b0;
            end else begin
              result_q    <= alu_res_d;
              flags_q     <= alu_flags_d;
              err_q       <= alu_err_d;
              out_valid_q <= 1'b1;
            end
          end else if (drain) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state_q     <= IDLE;
            result_q    <= mul_res;
            flags_q     <= mul_flags;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
